// File: rtl/sd_sector_memwr.sv
// Packs the SD sector byte stream into little-endian words and writes them to RAM through a small
// word FIFO and a req/ack port, raising done once the whole boot image has been written.
module sd_sector_memwr #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] BIN_SIZE   = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        in_en_i,
  input  logic [8:0]  in_addr_i,
  input  logic [7:0]  in_byte_i,
  output logic        almost_full_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] AfLevel = CntW'(FIFO_DEPTH - 1);
  localparam logic [32:0]     BinSize = {1'b0, BIN_SIZE};

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q, state_d;
  logic [32:0]     byte_cnt_q, byte_cnt_d;
  logic [8:0]      exp_q, exp_d;
  logic            skip_q, skip_d;
  logic            partial_q, partial_d;
  logic [23:0]     pack_q, pack_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     fifo_addr_q [FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic [31:0]     maddr_q, maddr_d, mdata_q, mdata_d;
  logic [30:0]     wr_words_q, wr_words_d;
  logic            done_q, done_d;
  logic [1:0]      err_q, err_d;

  logic        accept, complete, full, push, pop, overflow;
  logic [31:0] word;

  assign accept   = in_en_i && !done_q && (byte_cnt_q < BinSize);
  assign word     = {in_byte_i, pack_q};
  assign full     = (cnt_q == Depth);
  assign pop      = (state_q == StReq) && mem_ack_i;
  assign push     = complete && (!full || pop);
  assign overflow = complete && full && !pop;
  assign rd_next  = rd_ptr_q + 1'b1;

  // Byte packing and sequence tracking.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    exp_d      = exp_q;
    skip_d     = skip_q;
    partial_d  = partial_q;
    pack_d     = pack_q;
    complete   = 1'b0;
    err_d      = {err_q[1] | overflow, err_q[0]};
    if (accept) begin
      byte_cnt_d = byte_cnt_q + 33'd1;
      exp_d      = in_addr_i + 9'd1;
      if (in_addr_i != exp_q) begin
        err_d[0]  = 1'b1;
        skip_d    = 1'b1;
        partial_d = 1'b0;
        pack_d    = '0;
      end else if (!skip_q || (in_addr_i[1:0] == 2'd0)) begin
        // After a resync only a word-aligned byte may start a new word.
        skip_d    = 1'b0;
        partial_d = (in_addr_i[1:0] != 2'd3);
        unique case (in_addr_i[1:0])
          2'd0: pack_d[7:0]   = in_byte_i;
          2'd1: pack_d[15:8]  = in_byte_i;
          2'd2: pack_d[23:16] = in_byte_i;
          2'd3: begin
            complete = 1'b1;
            pack_d   = '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign waddr_d = complete ? (waddr_q + 32'd4) : waddr_q;
  assign cnt_d   = cnt_q + CntW'(push) - CntW'(pop);

  // Write FSM.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    maddr_d    = maddr_q;
    mdata_d    = mdata_q;
    wr_words_d = wr_words_q;
    done_d     = done_q;
    unique case (state_q)
      StIdle: begin
        if ((cnt_q != '0) && !done_q) begin
          req_d   = 1'b1;
          maddr_d = fifo_addr_q[rd_ptr_q];
          mdata_d = fifo_data_q[rd_ptr_q];
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ack_i) begin
          wr_words_d = wr_words_q + 31'd1;
          if ({wr_words_d, 2'b00} == BinSize) begin
            done_d  = 1'b1;
            req_d   = 1'b0;
            state_d = StIdle;
          end else if (cnt_q >= CntW'(2)) begin
            maddr_d = fifo_addr_q[rd_next];
            mdata_d = fifo_data_q[rd_next];
          end else begin
            req_d   = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      exp_q      <= '0;
      skip_q     <= 1'b0;
      partial_q  <= 1'b0;
      pack_q     <= '0;
      waddr_q    <= BASE_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      maddr_q    <= '0;
      mdata_q    <= '0;
      wr_words_q <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      exp_q      <= exp_d;
      skip_q     <= skip_d;
      partial_q  <= partial_d;
      pack_q     <= pack_d;
      waddr_q    <= waddr_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      maddr_q    <= maddr_d;
      mdata_q    <= mdata_d;
      wr_words_q <= wr_words_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= waddr_q;
        fifo_data_q[wr_ptr_q] <= word;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_next;
      end
    end
  end

  assign almost_full_o = (cnt_q >= AfLevel);
  assign mem_req_o     = req_q;
  assign mem_addr_o    = maddr_q;
  assign mem_wdata_o   = mdata_q;
  assign busy_o        = partial_q || (cnt_q != '0) || req_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule
